// File: rtl/half_adder_pkg.sv
// Shared definitions for the registered half adder datapath leaf.
// Centralises the default operand width used by half_adder instances.
package half_adder_pkg;

    localparam int unsigned HA_WIDTH_DEFAULT = 1;

endpackage

// File: rtl/half_adder_core.sv
// Purely combinational unsigned add of two operands with no carry-in.
// The extra MSB of sum is the carry-out.
module half_adder_core
    import half_adder_pkg::*;
#(
    parameter int unsigned WIDTH = HA_WIDTH_DEFAULT
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH:0]   sum
);

    assign sum = {1'b0, a} + {1'b0, b};

endmodule

// File: rtl/half_adder.sv
// Registered half adder: {c,s} = a + b captured one clock after in_valid.
// Outputs hold between accepted inputs; out_valid pulses once per accepted input.
module half_adder
    import half_adder_pkg::*;
#(
    parameter int unsigned WIDTH = HA_WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] s,
    output logic             c,
    output logic             out_valid
);

    logic [WIDTH:0]   sum;
    logic [WIDTH-1:0] s_d, s_q;
    logic             c_d, c_q;
    logic             out_valid_d, out_valid_q;

    half_adder_core #(
        .WIDTH(WIDTH)
    ) u_core (
        .a  (a),
        .b  (b),
        .sum(sum)
    );

    // Operands are only looked at when in_valid is high, so X on a/b is harmless otherwise.
    always_comb begin
        s_d         = s_q;
        c_d         = c_q;
        out_valid_d = 1'b0;
        if (in_valid) begin
            s_d         = sum[WIDTH-1:0];
            c_d         = sum[WIDTH];
            out_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s_q         <= '0;
            c_q         <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            s_q         <= s_d;
            c_q         <= c_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign s         = s_q;
    assign c         = c_q;
    assign out_valid = out_valid_q;

endmodule

// File: tb/tb_half_adder.sv
// Directed bench for half_adder at WIDTH=1, 4 and 8 with hand-computed expectations,
// plus a short random run on WIDTH=1 and WIDTH=8 against a behavioural reference.
module tb_half_adder;

    logic       clk;
    logic       rst_n;

    logic       v1, a1, b1, s1, c1, ov1;
    logic       v4, c4, ov4;
    logic [3:0] a4, b4, s4;
    logic       v8, c8, ov8;
    logic [7:0] a8, b8, s8;

    int checks;
    int failures;

    logic [8:0] exp8;
    logic [1:0] exp1;

    half_adder #(.WIDTH(1)) u_ha1 (
        .clk(clk), .rst_n(rst_n), .in_valid(v1), .a(a1), .b(b1),
        .s(s1), .c(c1), .out_valid(ov1)
    );

    half_adder #(.WIDTH(4)) u_ha4 (
        .clk(clk), .rst_n(rst_n), .in_valid(v4), .a(a4), .b(b4),
        .s(s4), .c(c4), .out_valid(ov4)
    );

    half_adder #(.WIDTH(8)) u_ha8 (
        .clk(clk), .rst_n(rst_n), .in_valid(v8), .a(a8), .b(b8),
        .s(s8), .c(c8), .out_valid(ov8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;

        // Reset held two cycles with a valid pending; nothing may get through.
        rst_n = 1'b0;
        v1 = 1'b1; a1 = 1'b1; b1 = 1'b1;
        v4 = 1'b1; a4 = 4'hF; b4 = 4'hF;
        v8 = 1'b1; a8 = 8'hFF; b8 = 8'h01;
        for (int i = 0; i < 2; i++) begin
            tick();
            check("rst_s1",  {31'd0, s1},  32'd0);
            check("rst_c1",  {31'd0, c1},  32'd0);
            check("rst_ov1", {31'd0, ov1}, 32'd0);
            check("rst_s4c4ov4", {26'd0, ov4, c4, s4}, 32'd0);
            check("rst_s8c8ov8", {22'd0, ov8, c8, s8}, 32'd0);
        end

        // WIDTH=1 truth table, back-to-back valids.
        rst_n = 1'b1;
        v4 = 1'b0; v8 = 1'b0;
        v1 = 1'b1; a1 = 1'b0; b1 = 1'b0;
        tick();
        check("tt00", {29'd0, ov1, c1, s1}, 32'b100);
        a1 = 1'b1; b1 = 1'b0;
        tick();
        check("tt10", {29'd0, ov1, c1, s1}, 32'b101);
        a1 = 1'b0; b1 = 1'b1;
        tick();
        check("tt01", {29'd0, ov1, c1, s1}, 32'b101);
        a1 = 1'b1; b1 = 1'b1;
        tick();
        check("tt11", {29'd0, ov1, c1, s1}, 32'b110);

        // Hold: invalid inputs, including X, leave s/c alone.
        v1 = 1'b0; a1 = 1'b0; b1 = 1'b1;
        tick();
        check("hold", {29'd0, ov1, c1, s1}, 32'b010);
        a1 = 1'bx; b1 = 1'bx;
        tick();
        check("hold_x", {29'd0, ov1, c1, s1}, 32'b010);
        a1 = 1'b0; b1 = 1'b0;

        // WIDTH=4 wrap-around cases.
        v4 = 1'b1; a4 = 4'hF; b4 = 4'h1;
        tick();
        check("w4_f_1", {26'd0, ov4, c4, s4}, {26'd0, 1'b1, 1'b1, 4'h0});
        a4 = 4'hF; b4 = 4'hF;
        tick();
        check("w4_f_f", {26'd0, ov4, c4, s4}, {26'd0, 1'b1, 1'b1, 4'hE});
        a4 = 4'h3; b4 = 4'h4;
        tick();
        check("w4_3_4", {26'd0, ov4, c4, s4}, {26'd0, 1'b1, 1'b0, 4'h7});
        v4 = 1'b0; a4 = 4'bxxxx; b4 = 4'bxxxx;
        tick();
        check("w4_hold_x", {26'd0, ov4, c4, s4}, {26'd0, 1'b0, 1'b0, 4'h7});
        a4 = 4'h0; b4 = 4'h0;

        // Mid-stream reset on WIDTH=8 with a valid every cycle.
        v8 = 1'b1; a8 = 8'd10; b8 = 8'd20;
        tick();
        check("ms_pre", {22'd0, ov8, c8, s8}, {22'd0, 1'b1, 1'b0, 8'd30});
        rst_n = 1'b0; a8 = 8'd200; b8 = 8'd100;
        tick();
        check("ms_rst8", {22'd0, ov8, c8, s8}, 32'd0);
        check("ms_rst4", {26'd0, ov4, c4, s4}, 32'd0);
        check("ms_rst1", {29'd0, ov1, c1, s1}, 32'd0);
        rst_n = 1'b1;
        tick();
        check("ms_resume", {22'd0, ov8, c8, s8}, {22'd0, 1'b1, 1'b1, 8'h2C});

        // Random run; references start from the state established above.
        exp8 = 9'h12C;
        exp1 = 2'b00;
        for (int i = 0; i < 200; i++) begin
            logic [7:0] ra, rb;
            logic       rv8, rv1, ra1, rb1;
            ra  = 8'($urandom);
            rb  = 8'($urandom);
            rv8 = 1'($urandom_range(0, 3) != 0);
            rv1 = 1'($urandom_range(0, 1));
            ra1 = 1'($urandom);
            rb1 = 1'($urandom);
            v8 = rv8; a8 = ra; b8 = rb;
            v1 = rv1; a1 = ra1; b1 = rb1;
            tick();
            if (rv8) exp8 = 9'(ra) + 9'(rb);
            if (rv1) exp1 = 2'(ra1) + 2'(rb1);
            check("rnd8", {22'd0, ov8, c8, s8}, {22'd0, rv8, exp8});
            check("rnd1", {29'd0, ov1, c1, s1}, {29'd0, rv1, exp1});
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
